// File: rtl/cvxif_copro_pkg.sv
// cvxif_copro_pkg: shared types and constants for the CV-X-IF coprocessor responder.
// CVXIF_COPRO_RS3_EN adds a third source operand and the CUS_ADD3 instruction.
package cvxif_copro_pkg;
    localparam int CX_XLEN = 32;
    localparam int CX_ID_W = 3;
    localparam int CNT_W = 8;
`ifdef CVXIF_COPRO_RS3_EN
    localparam int NRS = 3;
`else
    localparam int NRS = 2;
`endif
    localparam logic [6:0] CUSTOM0_OPCODE = 7'h0B;
    typedef enum logic [2:0] {CUS_ADD = 3'd0, CUS_NOP = 3'd1, CUS_MUL = 3'd2, CUS_ADD3 = 3'd3} funct3_e;
    typedef struct packed {
        logic accept;
        logic writeback;
        logic [CNT_W-1:0] lat;
    } decode_t;
    typedef struct packed {
        logic valid;
        logic [CX_ID_W-1:0] id;
        logic [4:0] rd;
        logic [CX_XLEN-1:0] data;
        logic we;
        logic committed;
        logic killed;
        logic [CNT_W-1:0] cnt;
    } entry_t;
endpackage

// File: rtl/cvxif_copro_alu.sv
// cvxif_copro_alu: combinational custom-0 decode and result computation.
// CVXIF_COPRO_RS3_EN enables CUS_ADD3 on the third operand slice.
module cvxif_copro_alu
    import cvxif_copro_pkg::*;
#(
    parameter int XLEN = CX_XLEN,
    parameter int MUL_LAT = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [NRS*XLEN-1:0] rs,
    input  logic [NRS-1:0]      rs_valid,
    output decode_t             dec,
    output logic [XLEN-1:0]     result
);
    logic [XLEN-1:0] rs1, rs2;
    logic ok;
    always_comb begin
        rs1 = rs[XLEN-1:0];
        rs2 = rs[2*XLEN-1:XLEN];
        ok = (opcode == CUSTOM0_OPCODE) && (&rs_valid[1:0]);
        dec = '0;
        result = '0;
        case (funct3)
            CUS_ADD: begin
                dec.accept = ok;
                dec.writeback = ok;
                result = rs1 + rs2;
            end
            CUS_NOP: dec.accept = ok;
            CUS_MUL: begin
                dec.accept = ok;
                dec.writeback = ok;
                dec.lat = CNT_W'(MUL_LAT - 1);
                result = rs1 * rs2;
            end
`ifdef CVXIF_COPRO_RS3_EN
            CUS_ADD3: begin
                dec.accept = ok && rs_valid[2];
                dec.writeback = ok && rs_valid[2];
                result = rs1 + rs2 + rs[3*XLEN-1:2*XLEN];
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/cvxif_copro_responder.sv
// cvxif_copro_responder: CV-X-IF responder with an in-order in-flight buffer.
// CVXIF_COPRO_RS3_EN widens the operand ports to three sources.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int XLEN = CX_XLEN,
    parameter int ID_WIDTH = CX_ID_W,
    parameter int DEPTH = 4,
    parameter int MUL_LAT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [NRS*XLEN-1:0] issue_rs_i,
    input  logic [NRS-1:0]      issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                result_we_o
);
    localparam int PW = $clog2(DEPTH);
    entry_t ent_q [DEPTH];
    entry_t hd;
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    decode_t dec;
    logic [XLEN-1:0] alu_res;
    logic push, pop, same_id;
    logic unused_instr;
    assign unused_instr = ^issue_instr_i[31:15];

    cvxif_copro_alu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) alu (
        .opcode(issue_instr_i[6:0]),
        .funct3(issue_instr_i[14:12]),
        .rs(issue_rs_i),
        .rs_valid(issue_rs_valid_i),
        .dec(dec),
        .result(alu_res)
    );

    always_comb begin
        hd = ent_q[head];
        issue_ready_o = count != (PW+1)'(DEPTH);
        issue_accept_o = dec.accept;
        issue_writeback_o = dec.writeback;
        result_valid_o = hd.valid && hd.committed && !hd.killed && hd.we && hd.cnt == '0;
        result_id_o = result_valid_o ? hd.id : '0;
        result_rd_o = result_valid_o ? hd.rd : '0;
        result_data_o = result_valid_o ? hd.data : '0;
        result_we_o = result_valid_o;
        pop = hd.valid && (hd.killed || (hd.committed && !hd.we) || (result_valid_o && result_ready_i));
        push = issue_valid_i && issue_ready_o && dec.accept;
        same_id = commit_valid_i && commit_id_i == issue_id_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].cnt != '0) ent_q[i].cnt <= ent_q[i].cnt - 1'b1;
                if (commit_valid_i && ent_q[i].valid && ent_q[i].id == commit_id_i) begin
                    if (commit_kill_i) ent_q[i].killed <= 1'b1;
                    else ent_q[i].committed <= 1'b1;
                end
            end
            // a commit aimed at the ID being pushed this cycle lands on the new entry
            if (push) begin
                ent_q[tail] <= '{valid: 1'b1, id: issue_id_i, rd: issue_instr_i[11:7], data: alu_res,
                                 we: dec.writeback, committed: same_id && !commit_kill_i,
                                 killed: same_id && commit_kill_i, cnt: dec.lat};
                tail <= tail + 1'b1;
            end
            if (pop) begin
                ent_q[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_cvxif_copro_responder.sv
// tb_cvxif_copro_responder: directed self-checking bench for the CV-X-IF responder.
module tb_cvxif_copro_responder;
    import cvxif_copro_pkg::*;
    logic clk = 0, rst_i = 1;
    logic issue_valid_i = 0, issue_ready_o, issue_accept_o, issue_writeback_o;
    logic [31:0] issue_instr_i = '0;
    logic [2:0] issue_id_i = '0, commit_id_i = '0, result_id_o;
    logic [NRS*32-1:0] issue_rs_i = '0;
    logic [NRS-1:0] issue_rs_valid_i = '0;
    logic commit_valid_i = 0, commit_kill_i = 0;
    logic result_valid_o, result_ready_i = 1, result_we_o;
    logic [4:0] result_rd_o;
    logic [31:0] result_data_o;
    int checks = 0, errors = 0;

    cvxif_copro_responder #(.XLEN(32), .ID_WIDTH(3), .DEPTH(4), .MUL_LAT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o),
        .result_data_o(result_data_o), .result_we_o(result_we_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [2:0] id, input logic [31:0] a, input logic [31:0] b,
                         input logic [NRS-1:0] v);
        issue_valid_i = 1;
        issue_instr_i = {17'b0, f3, rd, op};
        issue_id_i = id;
        issue_rs_i = '0;
        issue_rs_i[31:0] = a;
        issue_rs_i[63:32] = b;
        issue_rs_valid_i = v;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1;
        commit_id_i = id;
        commit_kill_i = kill;
    endtask

    task automatic test_reset();
        rst_i = 1;
        step();
        step();
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", issue_ready_o); end
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid_o); end
        checks++; if (result_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", result_we_o); end
        checks++; if (result_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", result_data_o); end
        checks++; if (result_id_o !== 3'd0 || result_rd_o !== 5'd0) begin errors++; $display("FAIL reset_id_rd got %0d/%0d exp 0/0", result_id_o, result_rd_o); end
        rst_i = 0;
        step();
    endtask

    task automatic test_add();
        issue(7'h0B, 3'd0, 5'd5, 3'd3, 32'hFFFF_FFFF, 32'd2, '1);
        #1;
        checks++; if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1) begin errors++; $display("FAIL add_decode got acc=%b wb=%b exp 1/1", issue_accept_o, issue_writeback_o); end
        step();
        issue_valid_i = 0;
        commit(3'd3, 0);
        #1;
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_uncommitted_valid got %b exp 0", result_valid_o); end
        step();
        commit_valid_i = 0;
        checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", result_valid_o); end
        checks++; if (result_data_o !== 32'd1) begin errors++; $display("FAIL add_data got %h exp 1", result_data_o); end
        checks++; if (result_id_o !== 3'd3 || result_rd_o !== 5'd5 || result_we_o !== 1'b1) begin errors++; $display("FAIL add_fields got id=%0d rd=%0d we=%b exp 3/5/1", result_id_o, result_rd_o, result_we_o); end
        step();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL add_popped got %b exp 0", result_valid_o); end
    endtask

    task automatic test_mul_order();
        issue(7'h0B, 3'd2, 5'd7, 3'd1, 32'd7, 32'd6, '1);
        commit(3'd1, 0);
        step();
        issue(7'h0B, 3'd0, 5'd6, 3'd2, 32'd10, 32'd20, '1);
        commit(3'd2, 0);
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early1 got %b exp 0", result_valid_o); end
        step();
        issue_valid_i = 0;
        commit_valid_i = 0;
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early2 got %b exp 0", result_valid_o); end
        step();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early3 got %b exp 0", result_valid_o); end
        step();
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd1 || result_data_o !== 32'd42) begin errors++; $display("FAIL mul_result got v=%b id=%0d data=%0d exp 1/1/42", result_valid_o, result_id_o, result_data_o); end
        step();
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd2 || result_data_o !== 32'd30) begin errors++; $display("FAIL mul_follow got v=%b id=%0d data=%0d exp 1/2/30", result_valid_o, result_id_o, result_data_o); end
        step();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mul_drained got %b exp 0", result_valid_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            issue(7'h0B, 3'd0, 5'd1, 3'(i), 32'(i * 16), 32'd1, '1);
            step();
        end
        issue(7'h0B, 3'd0, 5'd1, 3'd4, 32'd0, 32'd1, '1);
        #1;
        checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", issue_ready_o); end
        commit(3'd0, 1);
        step();
        issue_valid_i = 0;
        commit(3'd1, 0);
        checks++; if (issue_ready_o !== 1'b0 || result_valid_o !== 1'b0) begin errors++; $display("FAIL full_killed_head got rdy=%b v=%b exp 0/0", issue_ready_o, result_valid_o); end
        step();
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_back got %b exp 1", issue_ready_o); end
        for (int i = 1; i < 4; i++) begin
            if (i < 3) commit(3'(i + 1), 0);
            else commit_valid_i = 0;
            checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'(i) || result_data_o !== 32'(i * 16 + 1)) begin errors++; $display("FAIL full_order%0d got v=%b id=%0d data=%0d exp 1/%0d/%0d", i, result_valid_o, result_id_o, result_data_o, i, i * 16 + 1); end
            step();
        end
        checks++; if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_drained got v=%b rdy=%b exp 0/1", result_valid_o, issue_ready_o); end
    endtask

    task automatic test_reject();
        issue(7'h33, 3'd0, 5'd2, 3'd7, 32'd1, 32'd1, '1);
        #1;
        checks++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0) begin errors++; $display("FAIL rej_opcode got acc=%b wb=%b exp 0/0", issue_accept_o, issue_writeback_o); end
        step();
        issue(7'h0B, 3'd0, 5'd2, 3'd7, 32'd1, 32'd1, NRS'(2'b01));
        #1;
        checks++; if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0) begin errors++; $display("FAIL rej_rsvalid got acc=%b wb=%b exp 0/0", issue_accept_o, issue_writeback_o); end
        step();
        issue(7'h0B, 3'd7, 5'd2, 3'd7, 32'd1, 32'd1, '1);
        #1;
        checks++; if (issue_accept_o !== 1'b0) begin errors++; $display("FAIL rej_funct3 got acc=%b exp 0", issue_accept_o); end
        step();
        issue(7'h0B, 3'd0, 5'd2, 3'd7, 32'd1, 32'd1, NRS'(2'b10));
        step();
        issue_valid_i = 0;
        commit(3'd7, 0);
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL rej_count got rdy=%b exp 1", issue_ready_o); end
        step();
        commit_valid_i = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rej_no_result got %b exp 0", result_valid_o); end
            step();
        end
    endtask

    task automatic test_backpressure();
        result_ready_i = 0;
        issue(7'h0B, 3'd0, 5'd9, 3'd4, 32'd100, 32'd23, '1);
        commit(3'd4, 0);
        step();
        issue_valid_i = 0;
        commit_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (result_valid_o !== 1'b1 || result_data_o !== 32'd123 || result_id_o !== 3'd4 || result_rd_o !== 5'd9 || result_we_o !== 1'b1) begin errors++; $display("FAIL stall%0d got v=%b d=%0d id=%0d rd=%0d we=%b exp 1/123/4/9/1", i, result_valid_o, result_data_o, result_id_o, result_rd_o, result_we_o); end
            step();
        end
        rst_i = 1;
        #1;
        checks++; if (result_valid_o !== 1'b0 || result_data_o !== 32'd0 || result_id_o !== 3'd0 || result_rd_o !== 5'd0 || result_we_o !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b d=%0d id=%0d rd=%0d we=%b exp all 0", result_valid_o, result_data_o, result_id_o, result_rd_o, result_we_o); end
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", issue_ready_o); end
        step();
        rst_i = 0;
        result_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_discard got %b exp 0", result_valid_o); end
        end
    endtask

    task automatic test_same_cycle();
        issue(7'h0B, 3'd0, 5'd3, 3'd5, 32'd5, 32'd6, '1);
        commit(3'd5, 0);
        step();
        issue_valid_i = 0;
        commit(3'd6, 0);
        checks++; if (result_valid_o !== 1'b1 || result_id_o !== 3'd5 || result_data_o !== 32'd11) begin errors++; $display("FAIL same_cycle got v=%b id=%0d d=%0d exp 1/5/11", result_valid_o, result_id_o, result_data_o); end
        step();
        commit_valid_i = 0;
        issue(7'h0B, 3'd0, 5'd4, 3'd6, 32'd1, 32'd2, '1);
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL same_popped got %b exp 0", result_valid_o); end
        step();
        issue_valid_i = 0;
        step();
        checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL absent_commit_effect got %b exp 0", result_valid_o); end
        commit(3'd6, 1);
        step();
        commit_valid_i = 0;
        step();
        checks++; if (result_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin errors++; $display("FAIL kill_cleanup got v=%b rdy=%b exp 0/1", result_valid_o, issue_ready_o); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_order();
        test_full();
        test_reject();
        test_backpressure();
        test_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cvxif_copro_responder.md
Name: cvxif_copro_responder

Overview:
- Coprocessor-side (responder) end of the CV-X-IF interface that the core drives as initiator when CvxifEn=1.
- Decodes custom-0 instructions offered on the issue channel and tracks them in an in-order buffer until commit or kill.
- Computes results, single-cycle or multi-cycle, and returns committed results on the result channel with valid/ready.
- Sits outside the core, between the core's CV-X-IF port and the platform.

Parameters:
- XLEN, 32, operand/result width.
- ID_WIDTH, 3, instruction ID width; covers 8 scoreboard entries.
- DEPTH, 4, in-flight buffer entries; power of two, >=2.
- MUL_LAT, 4, cycles from issue to result-ready for CUS_MUL; >=2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  responder can take a request
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction ID
- issue_rs_i  in  2*XLEN  rs1 in [XLEN-1:0], rs2 in upper half
- issue_rs_valid_i  in  2  operand valid flags
- issue_accept_o  out  1  instruction recognised and taken (combinational)
- issue_writeback_o  out  1  accepted instruction will write rd (combinational)
- commit_valid_i  in  1  commit/kill message valid
- commit_id_i  in  ID_WIDTH  target ID
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  result ID
- result_rd_o  out  5  destination register
- result_data_o  out  XLEN  result value
- result_we_o  out  1  register write enable

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high on rst_i.
- Reset: all entries invalid, and pointers and count zero. Outputs after reset: issue_ready_o=1; result_valid_o, result_we_o, result_data_o, result_id_o, result_rd_o=0. Reset mid-operation discards all entries with no result emitted.
- Decode: opcode must be 7'h0B and both issue_rs_valid_i bits must be set.
  - funct3 000 CUS_ADD: rd = rs1 + rs2 mod 2^XLEN, latency 1.
  - funct3 001 CUS_NOP: accepted, writeback=0.
  - funct3 010 CUS_MUL: low XLEN bits of rs1*rs2, ready MUL_LAT cycles after the issue handshake.
  - Any other case: accept=0, writeback=0.
- issue_ready_o = (count != DEPTH); registered-state based and independent of issue_valid_i. A handshake occurs when issue_valid_i && issue_ready_o. On a handshake with accept=1, push {id, rd, data/operands, we, committed=0, killed=0, cnt}. On a handshake with accept=0, allocate nothing.
- Commit: on commit_valid_i, every valid entry whose id matches is marked killed (kill=1) or committed (kill=0).
  - A commit in the same cycle as the push of that ID applies to the new entry.
  - A commit for an absent ID is ignored.
  - The initiator guarantees IDs are unique among in-flight entries.
- cnt decrements every cycle while nonzero.
- Head retirement, one action per cycle, in-order only:
  - killed: pop silently.
  - committed, we=0: pop silently.
  - committed, we=1, cnt=0: result_valid_o=1 with the head fields. Pop on result_ready_i.
  - otherwise: wait.
- result_* outputs are driven only from the head register and stay stable while valid && !ready.
- Full buffer: no issue, even if the head pops that cycle; there is no fall-through.
- A push and a pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- A kill arriving while the head is presenting a result (valid && !ready) withdraws it: result_valid_o drops the next cycle. The core kills only uncommitted IDs, so this is a defensive path.

Optional Feature:
- Macro: CVXIF_COPRO_RS3_EN.
- Defined:
  - issue_rs_i widens to 3*XLEN; rs3 is the top slice.
  - issue_rs_valid_i widens to 3 bits.
  - Adds funct3 011 CUS_ADD3: rd = rs1+rs2+rs3 mod 2^XLEN, latency 1. It requires all three valid bits.
  - The existing ops ignore bit 2.
- Undefined: 2-operand ports exactly as listed; funct3 011 is rejected.

Decomposition:
- Package cvxif_copro_pkg:
  - opcode constant CUSTOM0_OPCODE=7'h0B
  - funct3 enum {CUS_ADD, CUS_NOP, CUS_MUL, CUS_ADD3}
  - decode-result struct {accept, writeback, lat}
  - buffer entry struct {valid, id, rd, data, we, committed, killed, cnt}
- Sub-module cvxif_copro_alu:
  - combinational decode plus compute from instr/operands
  - the multi-cycle delay is modelled by the entry counter in the parent, not inside the ALU

Test Plan:
- CUS_ADD rs1=32'hFFFF_FFFF, rs2=2, ID 3; commit next cycle; result_ready_i=1 -> accept=1, writeback=1; result data=1, id=3, we=1 on the cycle after commit.
- CUS_MUL 7*6, ID 1; commit immediately -> result_valid_o rises exactly MUL_LAT cycles after issue with data 42. A CUS_ADD issued behind it (ID 2) is emitted strictly after it.
- Issue IDs 0..3 (full); issue_valid_i held -> issue_ready_o=0. Kill ID 0, commit 1..3 -> ID 0 dropped silently, results 1,2,3 in order, and issue_ready_o returns to 1 after the first pop.
- Opcode 7'h33, or rs_valid=2'b01 -> accept=0, writeback=0, count unchanged, no result ever.
- Backpressure: result_ready_i=0 for 5 cycles with a committed result -> all result_* outputs stable. Assert rst_i mid-stall -> all outputs 0 immediately; the entry never appears afterwards.
- Commit in the same cycle as issue for ID 5, and commit for a non-present ID 6 -> ID 5 result emitted; ID 6 message has no effect.
